// File: rtl/corr_pkt_sched_if.sv
// Byte-wide push bus from the packet scheduler into the shared downstream FIFO.
interface corr_pkt_sched_if #(
    parameter int FIFO_DEPTH = 50
);
    localparam int NFREE_W = $clog2(FIFO_DEPTH + 1);

    logic [7:0]         o_fifo_data;
    logic               o_fifo_push;
    logic [NFREE_W-1:0] i_fifo_nFree;

    modport master (output o_fifo_data, output o_fifo_push, input  i_fifo_nFree);
    modport slave  (input  o_fifo_data, input  o_fifo_push, output i_fifo_nFree);
endinterface

// File: rtl/corr_pkt_sched.sv
// Round-robin scheduler: one holding slot per correlator channel, whole packets
// written byte by byte into a shared FIFO, with saturating per-channel drop counters.
module corr_pkt_sched #(
    parameter int  N_CHAN     = 4,
    parameter int  PKT_BYTES  = 5,
    parameter int  FIFO_DEPTH = 50,
    localparam int CHAN_W     = (N_CHAN > 1) ? $clog2(N_CHAN) : 1,
    localparam int IDX_W      = (PKT_BYTES > 1) ? $clog2(PKT_BYTES) : 1,
    localparam int PKT_W      = 8 * PKT_BYTES
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_cg,
    input  logic                      i_flush,
    input  logic [N_CHAN-1:0]         i_req_strobe,
    input  logic [N_CHAN*PKT_W-1:0]   i_req_pkt,
    corr_pkt_sched_if.master          io_fifo,
    output logic [N_CHAN-1:0]         o_holdValid,
    output logic [CHAN_W-1:0]         o_grant,
    output logic                      o_busy,
    output logic [N_CHAN*8-1:0]       o_dropCount
);

    if (N_CHAN < 1 || PKT_BYTES < 1 || PKT_BYTES > FIFO_DEPTH) begin : g_bad_params
        $error("corr_pkt_sched: need N_CHAN>=1 and 1<=PKT_BYTES<=FIFO_DEPTH");
    end

    typedef enum logic {ST_IDLE, ST_SEND} state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic [N_CHAN-1:0]   r_hold_valid;
    logic [7:0]          r_hold_pkt [N_CHAN][PKT_BYTES];
    logic [7:0]          r_drop     [N_CHAN];
    logic [CHAN_W-1:0]   r_rr;
    logic [CHAN_W-1:0]   r_grant;
    logic [IDX_W-1:0]    r_idx;

    logic                w_any;
    logic                w_hi_found;
    logic [CHAN_W-1:0]   w_low;
    logic [CHAN_W-1:0]   w_hi;
    logic [CHAN_W-1:0]   w_pick;
    logic                w_start;
    logic                w_last;
    logic [N_CHAN-1:0]   w_free;
    logic [N_CHAN-1:0]   w_capture;
    logic [N_CHAN-1:0]   w_drop;

    // NOTE: every variable gets a default before any branch, so no path can infer a latch.
    always_comb begin
        w_any      = 1'b0;
        w_hi_found = 1'b0;
        w_low      = '0;
        w_hi       = '0;
        // Descending scans leave the lowest candidate overall and the lowest at/after r_rr.
        for (int c = N_CHAN - 1; c >= 0; c--) begin
            if (r_hold_valid[c]) begin
                w_any = 1'b1;
                w_low = CHAN_W'(c);
                if (c >= int'(r_rr)) begin
                    w_hi_found = 1'b1;
                    w_hi       = CHAN_W'(c);
                end
            end
        end
        w_pick = w_hi_found ? w_hi : w_low;
    end

    always_comb begin
        w_next_state        = r_state;
        w_start             = 1'b0;
        w_last              = 1'b0;
        io_fifo.o_fifo_push = 1'b0;
        io_fifo.o_fifo_data = 8'h00;
        case (r_state)
            ST_IDLE: begin
                if (w_any && int'(io_fifo.i_fifo_nFree) >= PKT_BYTES) begin
                    w_start      = 1'b1;
                    w_next_state = ST_SEND;
                end
            end
            ST_SEND: begin
                io_fifo.o_fifo_push = 1'b1;
                io_fifo.o_fifo_data = r_hold_pkt[r_grant][r_idx];
                if (int'(r_idx) == PKT_BYTES - 1) begin
                    w_last       = 1'b1;
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // A slot released on the last byte edge may accept a new packet on that same edge.
    always_comb begin
        w_free    = '0;
        w_capture = '0;
        w_drop    = '0;
        for (int c = 0; c < N_CHAN; c++) begin
            w_free[c]    = w_last && (int'(r_grant) == c);
            w_capture[c] = i_req_strobe[c] && (!r_hold_valid[c] || w_free[c]);
            w_drop[c]    = i_req_strobe[c] && !w_capture[c];
        end
    end

    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else if (i_cg) begin
            r_state <= i_flush ? ST_IDLE : w_next_state;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_hold_valid <= '0;
            r_rr         <= '0;
            r_grant      <= '0;
            r_idx        <= '0;
            for (int c = 0; c < N_CHAN; c++) r_drop[c] <= '0;
        end else if (i_cg) begin
            if (i_flush) begin
                r_hold_valid <= '0;
                r_idx        <= '0;
                for (int c = 0; c < N_CHAN; c++) r_drop[c] <= '0;
            end else begin
                r_hold_valid <= (r_hold_valid & ~w_free) | w_capture;
                for (int c = 0; c < N_CHAN; c++) begin
                    if (w_drop[c] && r_drop[c] != 8'hFF) r_drop[c] <= r_drop[c] + 8'd1;
                end
                if (w_start) begin
                    r_grant <= w_pick;
                    r_idx   <= '0;
                end else if (w_last) begin
                    r_idx <= '0;
                    r_rr  <= (int'(r_grant) == N_CHAN - 1) ? '0 : r_grant + 1'b1;
                end else if (r_state == ST_SEND) begin
                    r_idx <= r_idx + 1'b1;
                end
            end
        end
    end

    // NOTE: packet storage is not reset; r_hold_valid alone says whether a slot is meaningful.
    always_ff @(posedge i_clk) begin
        if (i_rst_n && i_cg && !i_flush) begin
            for (int c = 0; c < N_CHAN; c++) begin
                if (w_capture[c]) begin
                    for (int b = 0; b < PKT_BYTES; b++) begin
                        r_hold_pkt[c][b] <= i_req_pkt[c*PKT_W + 8*b +: 8];
                    end
                end
            end
        end
    end

    always_comb begin
        o_dropCount = '0;
        for (int c = 0; c < N_CHAN; c++) o_dropCount[8*c +: 8] = r_drop[c];
    end

    assign o_holdValid = r_hold_valid;
    assign o_grant     = r_grant;
    assign o_busy      = (r_state == ST_SEND);

endmodule

// File: tb/tb_corr_pkt_sched.sv
// Directed bench for corr_pkt_sched: expected FIFO bytes are queued at stimulus time
// and a negedge monitor pops and compares every push the FIFO would accept.
module tb_corr_pkt_sched;
    localparam int N_CHAN     = 4;
    localparam int PKT_BYTES  = 5;
    localparam int FIFO_DEPTH = 50;
    localparam int PKT_W      = 8 * PKT_BYTES;

    typedef struct {
        int         ch;
        logic [7:0] b;
    } exp_t;

    logic                    i_clk = 1'b0;
    logic                    i_rst_n;
    logic                    i_cg;
    logic                    i_flush;
    logic [N_CHAN-1:0]       i_req_strobe;
    logic [N_CHAN*PKT_W-1:0] i_req_pkt;
    logic [N_CHAN-1:0]       o_holdValid;
    logic [1:0]              o_grant;
    logic                    o_busy;
    logic [N_CHAN*8-1:0]     o_dropCount;

    corr_pkt_sched_if #(.FIFO_DEPTH(FIFO_DEPTH)) fifo_if ();

    corr_pkt_sched #(
        .N_CHAN(N_CHAN), .PKT_BYTES(PKT_BYTES), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_cg(i_cg), .i_flush(i_flush),
        .i_req_strobe(i_req_strobe), .i_req_pkt(i_req_pkt), .io_fifo(fifo_if),
        .o_holdValid(o_holdValid), .o_grant(o_grant), .o_busy(o_busy),
        .o_dropCount(o_dropCount)
    );

    always #5 i_clk = ~i_clk;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t exp_q[$];
    exp_t mon_e;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // The FIFO shares the gate, flush and reset, so only pushes it would keep are scored.
    always @(negedge i_clk) begin
        if (fifo_if.o_fifo_push === 1'b1 && i_rst_n && i_cg && !i_flush) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_push: got byte 0x%0h grant %0d, expected no push",
                         fifo_if.o_fifo_data, o_grant);
            end else begin
                mon_e = exp_q.pop_front();
                check("push_data", 64'(fifo_if.o_fifo_data), 64'(mon_e.b));
                check("push_grant", 64'(o_grant), 64'(mon_e.ch));
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge i_clk);
        #1;
    endtask

    task automatic set_pkt(input int c, input logic [PKT_W-1:0] val);
        i_req_pkt[c*PKT_W +: PKT_W] = val;
    endtask

    task automatic exp_pkt(input int c, input logic [PKT_W-1:0] val);
        for (int b = 0; b < PKT_BYTES; b++) exp_q.push_back('{c, val[8*b +: 8]});
    endtask

    task automatic strobe(input logic [N_CHAN-1:0] mask);
        i_req_strobe = mask;
        tick();
        i_req_strobe = '0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((o_busy || o_holdValid != 0) && n < 200) begin
            tick();
            n++;
        end
        check(name, 64'(o_busy || o_holdValid != 0), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        i_rst_n = 1'b0; i_cg = 1'b1; i_flush = 1'b0;
        i_req_strobe = '0; i_req_pkt = '0;
        fifo_if.i_fifo_nFree = 6'd50;
        tick(2);
        check("rst_push",  64'(fifo_if.o_fifo_push), 64'd0);
        check("rst_data",  64'(fifo_if.o_fifo_data), 64'd0);
        check("rst_busy",  64'(o_busy), 64'd0);
        check("rst_grant", 64'(o_grant), 64'd0);
        check("rst_hold",  64'(o_holdValid), 64'd0);
        check("rst_drop",  64'(o_dropCount), 64'd0);
        i_rst_n = 1'b1;
        tick();

        // Round-robin: all four at once from pointer 0, 6 cycles per packet.
        set_pkt(0, 40'h1413121110); set_pkt(1, 40'h2423222120);
        set_pkt(2, 40'h3433323130); set_pkt(3, 40'h4443424140);
        exp_pkt(0, 40'h1413121110); exp_pkt(1, 40'h2423222120);
        exp_pkt(2, 40'h3433323130); exp_pkt(3, 40'h4443424140);
        strobe(4'hF);
        check("rr_hold_all", 64'(o_holdValid), 64'hF);
        tick(23);
        check("rr_last_busy", 64'(o_busy), 64'd1);
        check("rr_last_grant", 64'(o_grant), 64'd3);
        tick();
        check("rr_done_24", 64'({o_busy, o_holdValid}), 64'd0);
        check("rr_drained", 64'(exp_q.size()), 64'd0);
        check("rr_no_drops", 64'(o_dropCount), 64'd0);

        set_pkt(0, 40'h5554535251); set_pkt(3, 40'h6564636261);
        exp_pkt(0, 40'h5554535251); exp_pkt(3, 40'h6564636261);
        strobe(4'b1001);
        wait_idle("rr2_idle");

        // Single channel 2: first push two edges after the strobe edge.
        set_pkt(2, 40'h0504030201);
        exp_pkt(2, 40'h0504030201);
        strobe(4'b0100);
        check("single_hold", 64'(o_holdValid), 64'b0100);
        check("single_no_push", 64'(fifo_if.o_fifo_push), 64'd0);
        tick();
        check("single_first_push", 64'(fifo_if.o_fifo_push), 64'd1);
        check("single_grant", 64'(o_grant), 64'd2);
        check("single_byte0", 64'(fifo_if.o_fifo_data), 64'h01);
        tick(4);
        check("single_last_hold", 64'(o_holdValid), 64'b0100);
        check("single_byte4", 64'(fifo_if.o_fifo_data), 64'h05);
        tick();
        check("single_hold_clr", 64'(o_holdValid), 64'd0);
        check("single_push_end", 64'(fifo_if.o_fifo_push), 64'd0);

        // Backpressure: 4 free bytes is not enough for a 5-byte packet.
        fifo_if.i_fifo_nFree = 6'd4;
        set_pkt(1, 40'hA5A4A3A2A1);
        exp_pkt(1, 40'hA5A4A3A2A1);
        strobe(4'b0010);
        tick(5);
        check("bp_no_push", 64'(fifo_if.o_fifo_push), 64'd0);
        check("bp_idle", 64'(o_busy), 64'd0);
        check("bp_hold", 64'(o_holdValid), 64'b0010);
        fifo_if.i_fifo_nFree = 6'd5;
        tick();
        check("bp_start", 64'(o_busy), 64'd1);
        check("bp_grant", 64'(o_grant), 64'd1);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("bp_contig", 64'(fifo_if.o_fifo_push), 64'd1);
        end
        tick();
        check("bp_end", 64'({o_busy, o_holdValid}), 64'd0);

        // Drop saturation on channel 0 while the FIFO is full.
        fifo_if.i_fifo_nFree = 6'd0;
        set_pkt(0, 40'hC5C4C3C2C1);
        exp_pkt(0, 40'hC5C4C3C2C1);
        strobe(4'b0001);
        set_pkt(0, 40'hDEADBEEF00);
        i_req_strobe = 4'b0001;
        tick(300);
        i_req_strobe = '0;
        check("sat_drop0", 64'(o_dropCount[7:0]), 64'd255);
        check("sat_drop_other", 64'(o_dropCount[31:8]), 64'd0);
        check("sat_hold", 64'(o_holdValid), 64'b0001);
        fifo_if.i_fifo_nFree = 6'd50;
        wait_idle("sat_send_idle");
        check("sat_drop_kept", 64'(o_dropCount[7:0]), 64'd255);
        i_flush = 1'b1;
        tick();
        i_flush = 1'b0;
        check("flush_clr_drop", 64'(o_dropCount), 64'd0);

        // Strobe on the last byte edge of the same channel is captured without a drop.
        set_pkt(0, 40'hE5E4E3E2E1);
        exp_pkt(0, 40'hE5E4E3E2E1);
        strobe(4'b0001);
        tick();
        check("lb_grant", 64'(o_grant), 64'd0);
        tick(4);
        check("lb_last_byte", 64'(fifo_if.o_fifo_data), 64'hE5);
        set_pkt(0, 40'hF5F4F3F2F1);
        exp_pkt(0, 40'hF5F4F3F2F1);
        strobe(4'b0001);
        check("lb_hold", 64'(o_holdValid), 64'b0001);
        check("lb_no_drop", 64'(o_dropCount[7:0]), 64'd0);
        wait_idle("lb_idle");

        // Flush mid-packet: pointer is 1, so channel 2 wins over 3, then gets flushed.
        fifo_if.i_fifo_nFree = 6'd0;
        set_pkt(3, 40'h1A1B1C1D1E);
        strobe(4'b1000);
        set_pkt(2, 40'h2E2D2C2B2A);
        strobe(4'b0100);
        strobe(4'b1000);
        check("fl_drop3", 64'(o_dropCount[31:24]), 64'd1);
        exp_q.push_back('{2, 8'h2A});
        exp_q.push_back('{2, 8'h2B});
        fifo_if.i_fifo_nFree = 6'd50;
        tick();
        check("fl_grant", 64'(o_grant), 64'd2);
        tick(2);
        i_flush = 1'b1;
        i_req_strobe = 4'b0010;
        tick();
        i_flush = 1'b0;
        i_req_strobe = '0;
        check("fl_push_low", 64'(fifo_if.o_fifo_push), 64'd0);
        check("fl_hold", 64'(o_holdValid), 64'd0);
        check("fl_drop", 64'(o_dropCount), 64'd0);
        check("fl_drained", 64'(exp_q.size()), 64'd0);
        set_pkt(2, 40'h3E3D3C3B3A); set_pkt(3, 40'h4A4B4C4D4E);
        exp_pkt(2, 40'h3E3D3C3B3A); exp_pkt(3, 40'h4A4B4C4D4E);
        strobe(4'b1100);
        wait_idle("fl_after_idle");

        // Reset mid-SEND.
        set_pkt(1, 40'h7574737271);
        exp_q.push_back('{1, 8'h71});
        strobe(4'b0010);
        tick(2);
        i_rst_n = 1'b0;
        tick();
        check("rm_push", 64'(fifo_if.o_fifo_push), 64'd0);
        check("rm_data", 64'(fifo_if.o_fifo_data), 64'd0);
        check("rm_state", 64'({o_busy, o_grant, o_holdValid}), 64'd0);
        check("rm_drained", 64'(exp_q.size()), 64'd0);
        i_rst_n = 1'b1;

        // Clock gate mid-SEND: index freezes and strobes are ignored.
        set_pkt(3, 40'h8584838281);
        exp_pkt(3, 40'h8584838281);
        strobe(4'b1000);
        tick(2);
        i_cg = 1'b0;
        i_req_strobe = 4'b0001;
        tick(10);
        i_req_strobe = '0;
        check("cg_busy", 64'(o_busy), 64'd1);
        check("cg_frozen_byte", 64'(fifo_if.o_fifo_data), 64'h82);
        check("cg_hold", 64'(o_holdValid), 64'b1000);
        check("cg_no_drop", 64'(o_dropCount), 64'd0);
        i_cg = 1'b1;
        wait_idle("cg_idle");

        check("final_drained", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/corr_pkt_sched.md
Name: corr_pkt_sched

Overview:
Schedules result packets from up to N_CHAN correlator channels into the single shared byte-wide packet FIFO that is drained over BytePipe.
- Each channel pulses a strobe when its window wraps, presenting a PKT_BYTES-byte packet.
- The block holds one packet per channel and grants the FIFO round-robin.
- It writes each packet atomically, byte by byte, and counts packets dropped because a channel's holding slot was still full.

Parameters:
N_CHAN, 4, number of requesting correlator channels (>=1).
PKT_BYTES, 5, bytes per packet (1..FIFO_DEPTH).
FIFO_DEPTH, 50, depth in bytes of the downstream FIFO; sets i_fifo_nFree width.
CHAN_W (localparam), max($clog2(N_CHAN),1), width of the channel index.
NFREE_W (localparam), $clog2(FIFO_DEPTH+1), width of the free-entry count.

Ports:
i_clk  input  1  clock
i_rst_n  input  1  synchronous reset, active-low
i_cg  input  1  clock-gate enable; when 0 all state holds and strobes are ignored
i_flush  input  1  abort the current packet, empty all holding slots, clear drop counters
i_req_strobe  input  N_CHAN  per-channel one-cycle packet-available pulse
i_req_pkt  input  N_CHAN*8*PKT_BYTES  channel c packet at [c*8*PKT_BYTES +: 8*PKT_BYTES]; sampled only on a strobe
i_fifo_nFree  input  NFREE_W  free entries in the downstream FIFO
o_fifo_data  output  8  byte to push
o_fifo_push  output  1  push strobe
o_holdValid  output  N_CHAN  holding slot occupied, per channel
o_grant  output  CHAN_W  channel currently being sent (valid while o_busy)
o_busy  output  1  FSM in SEND
o_dropCount  output  N_CHAN*8  per-channel dropped-packet count, saturating at 255

Behaviour:
- Reset (i_rst_n==0 at a clock edge):
  - holding slots empty; FSM in IDLE; RR pointer=0; byte index=0; drop counts=0.
  - o_fifo_push=0, o_fifo_data=0, o_busy=0, o_grant=0, o_holdValid=0.
- All state updates require i_cg=1. i_rst_n has priority over i_flush; i_flush has priority over everything else.
- Capture, per channel c, on a cycle with i_req_strobe[c]=1:
  - Slot empty, or freed this same cycle: latch the packet and set holdValid[c]. Capture wins over clear, with no drop.
  - Otherwise: discard the new packet, keep the held one, increment dropCount[c] (saturating at 255).
- FSM has two states, IDLE and SEND.
- IDLE:
  - Candidates = holdValid (registered value, not this cycle's strobes).
  - If any candidate exists and i_fifo_nFree >= PKT_BYTES: grant the first candidate at or after the RR pointer (wrapping modulo N_CHAN), set o_grant, byte index=0, go to SEND. No push in this cycle.
  - Otherwise stay in IDLE. Never start a packet without room for the whole packet.
- SEND:
  - Each cycle: o_fifo_push=1, o_fifo_data = held[grant][8*idx +: 8] (LSB byte first), idx++.
  - o_fifo_push and o_fifo_data are combinational from the registered state and index.
  - On idx==PKT_BYTES-1: clear holdValid[grant], set RR pointer = (grant+1) mod N_CHAN, go to IDLE.
- Timing:
  - Packet cost is PKT_BYTES+1 cycles.
  - Latency from strobe to first push is at least 2 cycles: the strobe edge captures, the next edge decides in IDLE, and the push is visible in the cycle after that.
- SEND does not check i_fifo_nFree; the IDLE check guarantees space. Pushing into a full FIFO is a verification error.
- i_flush:
  - FSM to IDLE, idx=0, all holdValid=0, drop counts=0; RR pointer retained.
  - Strobes in the flush cycle are discarded and not counted.
  - o_fifo_push=0 in the cycle after the flush edge.
  - A partial packet may remain in the FIFO; the FIFO is flushed by the same i_flush.
- The held packet is immutable while in SEND; a strobe for the granted channel during SEND before the last byte is a drop.
- With N_CHAN=1 the RR pointer is a constant 0.

Test Plan:
- Single channel: N_CHAN=4, strobe ch2 with pkt 0x0504030201, nFree=50 -> pushes 01,02,03,04,05 on five consecutive cycles; first push 2 cycles after the strobe; o_grant=2; holdValid[2] clears with the last byte.
- Round-robin: strobe ch0..ch3 in the same cycle -> packets emitted in order 0,1,2,3. Then re-strobe ch0 and ch3 while the pointer=0 -> order 0,3. Total 4*6 cycles for the first batch, no drops.
- Backpressure: holdValid[1]=1 with nFree=4 -> no push, FSM stays IDLE. Raise nFree to 5 -> the packet starts the next cycle and pushes 5 bytes contiguously.
- Drop and saturation:
  - Strobe ch0 again while its slot is held (nFree=0) 300 times -> dropCount[0] reaches 255 and stays; the original packet is intact when later sent.
  - A strobe in the last SEND byte cycle of ch0 is captured with no drop.
- Flush mid-packet: assert i_flush after byte 2 of 5 -> push low the next cycle, holdValid=0, dropCount=0, RR pointer unchanged; the next granted packet starts at byte 0.
- Reset and clock gate:
  - i_rst_n=0 mid-SEND -> all outputs 0 after the edge.
  - i_cg=0 for 10 cycles mid-SEND -> the byte index freezes, and the stream resumes with no lost or duplicated byte.
